// File: rtl/zap_btb_pkg.sv
// Shared types for the BTB feedback path: branch-state codes, feedback entry, scheduler states.
package zap_btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } t_branch_state;

    typedef struct packed {
        logic        nok;
        logic [31:0] src;
        logic [1:0]  state;
        logic [31:0] dest;
    } t_btb_fb;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } t_sched_state;

endpackage

// File: rtl/zap_btb_fb_sched_if.sv
// One feedback requester port: valid/ready handshake carrying a single BTB update.
interface zap_btb_fb_sched_if;
    logic        valid;
    logic        ready;
    logic        nok;
    logic [31:0] src;
    logic [1:0]  state;
    logic [31:0] dest;

    modport master (output valid, output nok, output src, output state, output dest, input ready);
    modport slave  (input valid, input nok, input src, input state, input dest, output ready);
endinterface

// File: rtl/zap_btb_fb_fifo.sv
// Synchronous circular FIFO of BTB feedback entries; clear empties it in one cycle.
// Push is dropped when full and pop is ignored when empty.
module zap_btb_fb_fifo
    import zap_btb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  t_btb_fb       i_push_dat,
    input  logic          i_pop,
    output t_btb_fb       o_pop_dat,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    t_btb_fb       mem_q [DEPTH];

    logic do_push, do_pop;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == CW'(DEPTH));
    assign o_count   = count_q;
    assign o_pop_dat = mem_q[rd_ptr_q];
    assign do_push   = i_push & ~o_full;
    assign do_pop    = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_clear) mem_q[wr_ptr_q] <= i_push_dat;
    end

endmodule

// File: rtl/zap_btb_fb_sched.sv
// Round-robin scheduler funnelling two feedback requesters into the single BTB write port.
// Accept-to-strobe latency 2 cycles; readies drop when full, draining, or clearing.
module zap_btb_fb_sched
    import zap_btb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_drain_req,
    output logic                     o_drain_done,
    zap_btb_fb_sched_if.slave        rq0,
    zap_btb_fb_sched_if.slave        rq1,
    output logic                     o_fb_ok,
    output logic                     o_fb_nok,
    output logic [31:0]              o_fb_branch_src_address,
    output logic [1:0]               o_fb_current_branch_state,
    output logic [31:0]              o_fb_branch_dest_address,
    output logic                     o_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    t_sched_state  state_q;
    logic          drain_done_q;
    logic          rr_ptr_q, rr_ptr_d;
    logic          fb_ok_q, fb_ok_d;
    logic          fb_nok_q, fb_nok_d;
    logic [31:0]   fb_src_q, fb_src_d;
    logic [1:0]    fb_state_q, fb_state_d;
    logic [31:0]   fb_dest_q, fb_dest_d;

    logic          can_acc, acc0, acc1, push, pop;
    t_btb_fb       push_dat, pop_dat;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;

    // A requester's ready never looks at its own valid, only at the competitor's,
    // so there is no valid->ready loop; an idle requester may see a harmless ready.
    assign can_acc   = (state_q == RUN) & ~i_clear & ~fifo_full;
    assign rq0.ready = can_acc & (~rr_ptr_q | ~rq1.valid);
    assign rq1.ready = can_acc & ( rr_ptr_q | ~rq0.valid);
    assign acc0      = rq0.valid & rq0.ready;
    assign acc1      = rq1.valid & rq1.ready;
    assign push      = acc0 | acc1;
    assign pop       = ~fifo_empty & ~i_clear;

    always_comb begin
        if (acc1) push_dat = '{nok: rq1.nok, src: rq1.src, state: rq1.state, dest: rq1.dest};
        else      push_dat = '{nok: rq0.nok, src: rq0.src, state: rq0.state, dest: rq0.dest};
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (acc0)      rr_ptr_d = 1'b1;
        else if (acc1) rr_ptr_d = 1'b0;
    end

    zap_btb_fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_clear),
        .i_push     (push),
        .i_push_dat (push_dat),
        .i_pop      (pop),
        .o_pop_dat  (pop_dat),
        .o_count    (fifo_count),
        .o_empty    (fifo_empty),
        .o_full     (fifo_full)
    );

    // Data fields hold between writes; only the strobes return to zero.
    always_comb begin
        fb_ok_d    = 1'b0;
        fb_nok_d   = 1'b0;
        fb_src_d   = fb_src_q;
        fb_state_d = fb_state_q;
        fb_dest_d  = fb_dest_q;
        if (pop) begin
            fb_ok_d    = ~pop_dat.nok;
            fb_nok_d   = pop_dat.nok;
            fb_src_d   = pop_dat.src;
            fb_state_d = pop_dat.state;
            fb_dest_d  = pop_dat.dest;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr_q   <= 1'b0;
            fb_ok_q    <= 1'b0;
            fb_nok_q   <= 1'b0;
            fb_src_q   <= '0;
            fb_state_q <= '0;
            fb_dest_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            fb_ok_q    <= fb_ok_d;
            fb_nok_q   <= fb_nok_d;
            fb_src_q   <= fb_src_d;
            fb_state_q <= fb_state_d;
            fb_dest_q  <= fb_dest_d;
        end
    end

    // Once drained the FIFO is empty and the final pop is already in the output
    // register, so the done pulse lands one cycle after the last strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (!i_clear && i_drain_req) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (i_clear || fifo_empty) begin
                        state_q      <= DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign o_drain_done              = drain_done_q;
    assign o_fb_ok                   = fb_ok_q;
    assign o_fb_nok                  = fb_nok_q;
    assign o_fb_branch_src_address   = fb_src_q;
    assign o_fb_current_branch_state = fb_state_q;
    assign o_fb_branch_dest_address  = fb_dest_q;
    assign o_busy                    = (fifo_count != '0) | fb_ok_q | fb_nok_q;

endmodule

// File: tb/tb_zap_btb_fb_sched.sv
// Bench for zap_btb_fb_sched: directed scenarios plus random traffic against a queue-based model.
module tb_zap_btb_fb_sched;
    import zap_btb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, dreq;
    logic        drain_done, fb_ok, fb_nok, busy;
    logic [31:0] fb_src, fb_dest;
    logic [1:0]  fb_state;

    zap_btb_fb_sched_if rq0_if ();
    zap_btb_fb_sched_if rq1_if ();

    zap_btb_fb_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk                     (clk),
        .i_reset                   (rst),
        .i_clear                   (clr),
        .i_drain_req               (dreq),
        .o_drain_done              (drain_done),
        .rq0                       (rq0_if),
        .rq1                       (rq1_if),
        .o_fb_ok                   (fb_ok),
        .o_fb_nok                  (fb_nok),
        .o_fb_branch_src_address   (fb_src),
        .o_fb_current_branch_state (fb_state),
        .o_fb_branch_dest_address  (fb_dest),
        .o_busy                    (busy)
    );

    // Model: pending entries as a queue, last written entry, mode 0=run 1=drain 2=done.
    t_btb_fb     mq[$];
    bit          m_ok, m_nok, m_ptr;
    logic [31:0] m_src, m_dest;
    logic [1:0]  m_state;
    int          m_mode;
    bit          e_r0, e_r1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ok = 0; m_nok = 0; m_ptr = 0; m_mode = 0;
        m_src = '0; m_dest = '0; m_state = '0;
    endfunction

    function automatic void check_model();
        bit open;
        open = (m_mode == 0) && !clr && (mq.size() < DEPTH);
        e_r0 = open && (m_ptr == 1'b0 || !rq1_if.valid);
        e_r1 = open && (m_ptr == 1'b1 || !rq0_if.valid);
        chk("rq0_ready", rq0_if.ready, e_r0);
        chk("rq1_ready", rq1_if.ready, e_r1);
        chk("fb_ok", fb_ok, m_ok);
        chk("fb_nok", fb_nok, m_nok);
        chk("fb_src", fb_src, m_src);
        chk("fb_state", fb_state, m_state);
        chk("fb_dest", fb_dest, m_dest);
        chk("drain_done", drain_done, m_mode == 2);
        chk("busy", busy, (mq.size() != 0) || m_ok || m_nok);
    endfunction

    function automatic void step_model();
        t_btb_fb e;
        int nm;
        if (rst) begin
            model_reset();
            return;
        end
        if (clr) begin
            mq.delete();
            m_ok = 0; m_nok = 0;
            m_mode = (m_mode == 1) ? 2 : 0;
            return;
        end
        nm = m_mode;
        if (m_mode == 0 && dreq)            nm = 1;
        if (m_mode == 1 && mq.size() == 0) nm = 2;
        if (m_mode == 2)                    nm = 0;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_ok = !e.nok; m_nok = e.nok;
            m_src = e.src; m_state = e.state; m_dest = e.dest;
        end else begin
            m_ok = 0; m_nok = 0;
        end
        if (rq0_if.valid && e_r0) begin
            mq.push_back('{nok: rq0_if.nok, src: rq0_if.src, state: rq0_if.state, dest: rq0_if.dest});
            m_ptr = 1;
        end else if (rq1_if.valid && e_r1) begin
            mq.push_back('{nok: rq1_if.nok, src: rq1_if.src, state: rq1_if.state, dest: rq1_if.dest});
            m_ptr = 0;
        end
        m_mode = nm;
    endfunction

    task automatic tick();
        @(negedge clk);
        check_model();
        step_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drv(input int r, input bit v, input bit nk, input logic [31:0] s,
                       input logic [1:0] st, input logic [31:0] d);
        if (r == 0) begin
            rq0_if.valid = v; rq0_if.nok = nk; rq0_if.src = s; rq0_if.state = st; rq0_if.dest = d;
        end else begin
            rq1_if.valid = v; rq1_if.nok = nk; rq1_if.src = s; rq1_if.state = st; rq1_if.dest = d;
        end
    endtask

    task automatic rnd(input int r, input bit v);
        drv(r, v, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
    endtask

    task automatic idle();
        rst = 0; clr = 0; dreq = 0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    int nstrobe, ndone, last_s, dcyc;

    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_ok", fb_ok, 0);
        chk("reset_nok", fb_nok, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", drain_done, 0);
        chk("reset_src", fb_src, 0);

        // Single entry: strobe two cycles after acceptance.
        drv(0, 1, 0, 32'h0000_1000, WT, 32'h0000_2000);
        #1;
        chk("t1_ready0", rq0_if.ready, 1);
        tick();
        idle();
        tick();
        chk("t1_ok", fb_ok, 1);
        chk("t1_nok", fb_nok, 0);
        chk("t1_src", fb_src, 32'h1000);
        chk("t1_state", fb_state, 2'd2);
        chk("t1_dest", fb_dest, 32'h2000);
        tick();
        chk("t1_ok_off", fb_ok, 0);
        tick();

        // Both requesters valid: grants alternate starting with rq0.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                drv(0, 1, 0, 32'h100, WNT, 32'h10);
                drv(1, 1, 1, 32'h200, ST, 32'h20);
            end else idle();
            #1;
            if (k < 4) begin
                chk("t2_ready0", rq0_if.ready, (k % 2) == 0);
                chk("t2_ready1", rq1_if.ready, (k % 2) == 1);
            end
            if (k >= 2) begin
                chk("t2_src", fb_src, ((k % 2) == 0) ? 32'h100 : 32'h200);
                chk("t2_nok", fb_nok, (k % 2) == 1);
            end
            tick();
        end

        // Back-to-back traffic on a 2-deep FIFO never stalls the requesters.
        for (int k = 0; k < 20; k++) begin
            rnd(0, 1);
            rnd(1, 1);
            #1;
            chk("t3_some_ready", rq0_if.ready | rq1_if.ready, 1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Drain: three strobes, done pulse one cycle after the last one.
        do_reset();
        nstrobe = 0; ndone = 0; last_s = -1; dcyc = -1;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i < 3) rnd(0, 1);
            if (i == 2) dreq = 1;
            #1;
            if (i == 3) chk("t4_ready_drain", rq0_if.ready, 0);
            if (fb_ok || fb_nok) begin nstrobe++; last_s = cyc; end
            if (drain_done) begin ndone++; dcyc = cyc; end
            tick();
        end
        chk("t4_strobes", nstrobe, 3);
        chk("t4_done_cnt", ndone, 1);
        chk("t4_done_time", dcyc, last_s + 1);
        rnd(0, 1);
        #1;
        chk("t4_ready_back", rq0_if.ready, 1);
        tick();
        idle();
        repeat (3) tick();

        // Clear while entries are in flight.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i < 3)  drv(0, 1, 0, 32'h300 + i, WT, 32'h400);
            if (i == 3) clr = 1;
            if (i == 6) drv(0, 1, 0, 32'h777, SNT, 32'h888);
            #1;
            if (i >= 4 && i <= 7) chk("t5_no_strobe", fb_ok | fb_nok, 0);
            if (i == 4) chk("t5_busy", busy, 0);
            if (i == 8) chk("t5_after_ok", fb_ok, 1);
            if (i == 8) chk("t5_after_src", fb_src, 32'h777);
            tick();
        end

        // Clear inside DRAIN forces DONE on the next cycle.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) begin rnd(0, 1); dreq = 1; end
            if (i == 1) clr = 1;
            #1;
            if (i == 1) chk("t6_done_early", drain_done, 0);
            if (i == 2) chk("t6_done", drain_done, 1);
            if (i == 3) chk("t6_done_once", drain_done, 0);
            tick();
        end

        // Reset mid-drain: no done pulse, back in RUN.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 0) begin rnd(0, 1); dreq = 1; end
            if (i == 1) rst = 1;
            if (i == 3) rnd(0, 1);
            #1;
            if (i >= 2) chk("t7_no_done", drain_done, 0);
            if (i == 3) chk("t7_run_ready", rq0_if.ready, 1);
            tick();
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 999) < 5);
            clr  = ($urandom_range(0, 99) < 2);
            dreq = ($urandom_range(0, 99) < 3);
            rnd(0, $urandom_range(0, 99) < 60);
            rnd(1, $urandom_range(0, 99) < 60);
            tick();
        end
        idle();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
